i2s_link_ctrl: RTL

I2S_LINK_CTRL -- requirements
Module: i2s_link_ctrl

---
 rtl/i2s_link_ctrl.sv | 90 +++++++++
 1 files changed

// File: rtl/i2s_link_ctrl.sv
// i2s_link_ctrl: I2S framer that serialises one held stereo pair per lrck frame onto sdout
// and deserialises the matching sdin pair, with one-deep tx holding register and underrun flag.
module i2s_link_ctrl #(
  parameter int WIDTH = 24,
  parameter int SLOT = 32
) (
  input  logic             mck,
  input  logic             reset,
  input  logic             bck,
  input  logic             lrck,
  input  logic             enable,
  input  logic [WIDTH-1:0] tx_left,
  input  logic [WIDTH-1:0] tx_right,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             sdout,
  input  logic             sdin,
  output logic [WIDTH-1:0] rx_left,
  output logic [WIDTH-1:0] rx_right,
  output logic             rx_valid,
  output logic             underrun,
  input  logic             clr_status,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [SLOT-WIDTH-1:0] PAD = '0;
  typedef enum logic [1:0] {IDLE, SYNC, LEFT, RIGHT} state_t;
  state_t state;
  logic bck_d, lrck_q, hold_full;
  logic [WIDTH-1:0] hold_l, hold_r, tx_buf_r, rx_sh, rx_hold;
  logic [SLOT-1:0] sh;
  logic [CW-1:0] cnt;
  logic fall, rise, frame_start, right_start, hs, tstart, rstart, load, quiet, rx_bit, rx_done;
  assign fall = bck_d & ~bck;
  assign rise = ~bck_d & bck;
  assign frame_start = fall & lrck_q & ~lrck;
  assign right_start = fall & ~lrck_q & lrck;
  assign tx_ready = ~hold_full & ~reset;
  assign hs = tx_valid & tx_ready;
  assign tstart = enable & frame_start & (state == SYNC || state == RIGHT);
  assign rstart = enable & right_start & (state == LEFT);
  assign load = tstart & hold_full;
  assign rx_done = tstart & (state == RIGHT);
  // channel starts and any non-running cycle restart the per-channel serial machinery
  assign quiet = tstart | rstart | ~enable | ~busy;
  assign rx_bit = rise & (cnt != '0) & (cnt <= CW'(WIDTH));
  always_ff @(posedge mck or posedge reset)
    if (reset) begin
      state <= IDLE;
      busy <= 1'b0;
      bck_d <= 1'b0;
      lrck_q <= 1'b0;
      hold_full <= 1'b0;
      hold_l <= '0;
      hold_r <= '0;
      tx_buf_r <= '0;
      sh <= '0;
      sdout <= 1'b0;
      cnt <= '0;
      rx_sh <= '0;
      rx_hold <= '0;
      rx_left <= '0;
      rx_right <= '0;
      rx_valid <= 1'b0;
      underrun <= 1'b0;
    end else begin
      bck_d <= bck;
      if (fall) lrck_q <= lrck;
      if (hs) begin
        hold_full <= 1'b1;
        hold_l <= tx_left;
        hold_r <= tx_right;
      end else if (load) hold_full <= 1'b0;
      underrun <= (tstart & ~hold_full) | (underrun & ~clr_status);
      state <= !enable ? IDLE : state == IDLE ? SYNC : tstart ? LEFT : rstart ? RIGHT : state;
      busy <= enable & (busy | tstart);
      if (tstart) tx_buf_r <= load ? hold_r : '0;
      // the load cycle drives the I2S delay bit; the sample MSB follows one bck later
      sh <= tstart ? {load ? hold_l : '0, PAD} : rstart ? {tx_buf_r, PAD} : (fall & busy) ? sh << 1 : sh;
      sdout <= quiet ? 1'b0 : fall ? sh[SLOT-1] : sdout;
      cnt <= quiet ? '0 : (rise && cnt <= CW'(WIDTH)) ? cnt + CW'(1) : cnt;
      rx_sh <= quiet ? '0 : rx_bit ? {rx_sh[WIDTH-2:0], sdin} : rx_sh;
      if (rstart) rx_hold <= rx_sh;
      rx_valid <= rx_done;
      if (rx_done) begin
        rx_left <= rx_hold;
        rx_right <= rx_sh;
      end
    end
endmodule
